spi_slave: RTL and testbench

- SPI responder (mode 0: CPOL=0, CPHA=0, MSB first). It is the far end of the existing spi_master link.
- Oversamples spi_clk, cs and mosi in the system clock domain.
- Deserialises mosi into parallel bytes and serialises queued response bytes onto miso.
- Sits on the peripheral side of the board, or in loopback against spi_master in simulation.

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_sync_edge.sv | 34 +++
 rtl/spi_slave.sv | 187 ++++++++++++++++++
 tb/tb_spi_slave.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions used by spi_slave and spi_master so both ends agree on word width.
package spi_pkg;

    localparam int                        SPI_DATA_WIDTH = 8;
    localparam logic [SPI_DATA_WIDTH-1:0] SPI_DEFAULT_TX = 8'h00;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_slave_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, plus single-cycle rise/fall
// pulses derived from the synchronised level (pin-to-pulse latency SYNC_STAGES).
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   level_s;
    logic                   level_q;

    assign level_s = sync_p[SYNC_STAGES-1];

    // Clearing to 0 means a pin already low at reset release can never produce a
    // fall pulse until it has first been seen high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p  <= '0;
            level_q <= 1'b0;
        end else begin
            sync_p  <= {sync_p[SYNC_STAGES-2:0], d};
            level_q <= level_s;
        end
    end

    assign rise = level_s & ~level_q;
    assign fall = ~level_s & level_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversampled serial link to parallel rx/tx words.
// Define SPI_SLAVE_OVERRUN_EN to enable the sticky rx overrun flag.
module spi_slave
    import spi_pkg::*;
#(
    parameter int                    DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = SPI_DEFAULT_TX
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_clk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  busy,
    output logic                  overrun
);

    localparam int               CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   cs_rise;
    logic                   cs_fall;
    logic [SYNC_STAGES-1:0] mosi_p;
    logic                   mosi_s;

    spi_slave_state_t       state_q;
    spi_slave_state_t       state_d;

    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_WIDTH-2:0]  rx_shift;
    logic [DATA_WIDTH-1:0]  rx_word;
    logic [DATA_WIDTH-1:0]  tx_shift;
    logic [DATA_WIDTH-1:0]  hold;
    logic                   hold_full;
    logic [DATA_WIDTH-1:0]  tx_load_word;

    logic                   enter;
    logic                   leave;
    logic                   bit_rise;
    logic                   bit_fall;
    logic                   word_done;
    logic                   load_pt;
    logic                   tx_capture;
    logic                   rx_ack;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .d     (spi_clk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk   (clk),
        .reset (reset),
        .d     (cs),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // mosi only needs the level, at the same depth as the spi_clk edge pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            mosi_p <= '0;
        end else begin
            mosi_p <= {mosi_p[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_s = mosi_p[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = ACTIVE;
            ACTIVE:  if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        miso = 1'b0;
        if (state_q == ACTIVE) begin
            busy = 1'b1;
            miso = tx_shift[DATA_WIDTH-1];
        end
    end

    // A cs rise masks any spi_clk edge arriving in the same cycle.
    assign enter        = (state_q == IDLE) && cs_fall;
    assign leave        = (state_q == ACTIVE) && cs_rise;
    assign bit_rise     = (state_q == ACTIVE) && !cs_rise && sclk_rise;
    assign bit_fall     = (state_q == ACTIVE) && !cs_rise && sclk_fall;
    assign word_done    = bit_rise && (bit_cnt == LAST_BIT);
    assign load_pt      = enter || (bit_fall && (bit_cnt == '0));
    assign tx_capture   = tx_valid && tx_ready;
    assign rx_ack       = rx_valid && rx_ready;
    assign rx_word      = {rx_shift, mosi_s};
    assign tx_load_word = hold_full ? hold : DEFAULT_TX;
    assign tx_ready     = !hold_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
        end else if (enter || leave) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
        end else if (bit_rise) begin
            rx_shift <= rx_word[DATA_WIDTH-2:0];
            bit_cnt  <= word_done ? '0 : bit_cnt + CNT_W'(1);
        end
    end

    // The load point sees hold as it was before any same-cycle capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_shift  <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            if (load_pt) begin
                tx_shift <= tx_load_word;
            end else if (bit_fall) begin
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end

            if (tx_capture) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end else if (load_pt) begin
                hold_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else if (word_done) begin
            rx_data  <= rx_word;
            rx_valid <= 1'b1;
        end else if (rx_ack) begin
            rx_valid <= 1'b0;
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (word_done && rx_valid && !rx_ready) begin
            overrun_q <= 1'b1;
        end else if (rx_ack && !word_done) begin
            overrun_q <= 1'b0;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: table-driven transactions, hand-written corner sequences and
// randomized multi-word transfers checked against a queue-based response model.
`timescale 1ns/1ps
module tb_spi_slave;

    localparam int         HALF       = 8;
    localparam logic [7:0] DEFAULT_TX = 8'h00;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_clk;
    logic       cs;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       busy;
    logic       overrun;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] tx_q[$];

    typedef struct {
        logic       queue;
        logic [7:0] txw;
        logic [7:0] mosi_w;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;

    always #5 clk = ~clk;

    spi_slave dut (
        .clk      (clk),
        .reset    (reset),
        .spi_clk  (spi_clk),
        .cs       (cs),
        .mosi     (mosi),
        .miso     (miso),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .busy     (busy),
        .overrun  (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Master side of one word: mosi set while spi_clk low, miso sampled at the rise.
    task automatic spi_word(input logic [7:0] w, input int nbits, output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = w[7-i];
            repeat (HALF) @(negedge clk);
            spi_clk = 1'b1;
            got = {got[6:0], miso};
            repeat (HALF) @(negedge clk);
            spi_clk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_low();
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        cs = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic ack_rx();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    // Every load point (cs entry, each word boundary) consumes the held word if any.
    task automatic model_load(output logic [7:0] w);
        if (tx_q.size() != 0) w = tx_q.pop_front();
        else w = DEFAULT_TX;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "simulation timeout");
    end

    initial begin
        vec_t       vecs[4];
        logic [7:0] got;
        logic [7:0] exp_miso;
        logic [7:0] mw;
        logic [7:0] qw;
        logic       exp_ovr;
        int         nw;

        reset    = 1'b1;
        cs       = 1'b1;
        spi_clk  = 1'b0;
        mosi     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);

        check("reset miso",     miso,     1'b0);
        check("reset rx_data",  rx_data,  8'h00);
        check("reset rx_valid", rx_valid, 1'b0);
        check("reset tx_ready", tx_ready, 1'b1);
        check("reset busy",     busy,     1'b0);
        check("reset overrun",  overrun,  1'b0);

        reset = 1'b0;
        repeat (5) @(negedge clk);

        vecs[0] = '{1'b0, 8'h00, 8'hA5, 8'hA5, 8'h00};
        vecs[1] = '{1'b1, 8'hC3, 8'h5A, 8'h5A, 8'hC3};
        vecs[2] = '{1'b0, 8'h00, 8'hFF, 8'hFF, 8'h00};
        vecs[3] = '{1'b1, 8'h81, 8'h00, 8'h00, 8'h81};

        foreach (vecs[i]) begin
            if (vecs[i].queue) begin
                check("vec tx_ready before queue", tx_ready, 1'b1);
                push_tx(vecs[i].txw);
                check("vec tx_ready after queue", tx_ready, 1'b0);
            end
            cs_low();
            check("vec busy", busy, 1'b1);
            spi_word(vecs[i].mosi_w, 8, got);
            cs_high();
            check("vec rx_valid", rx_valid, 1'b1);
            check("vec rx_data", rx_data, vecs[i].exp_rx);
            check("vec miso word", got, vecs[i].exp_miso);
            check("vec tx_ready after", tx_ready, 1'b1);
            check("vec busy idle", busy, 1'b0);
            ack_rx();
            check("vec rx_valid cleared", rx_valid, 1'b0);
        end

        // Held word consumed three clocks after the cs pin falls.
        push_tx(8'h3C);
        check("hold tx_ready low", tx_ready, 1'b0);
        cs = 1'b0;
        repeat (2) @(negedge clk);
        check("tx_ready at cs+2", tx_ready, 1'b0);
        @(negedge clk);
        check("tx_ready at cs+3", tx_ready, 1'b1);
        repeat (HALF - 3) @(negedge clk);
        spi_word(8'h00, 8, got);
        check("3C miso word", got, 8'h3C);
        cs_high();
        check("3C rx_data", rx_data, 8'h00);
        ack_rx();

        // Back-to-back words without a cs toggle; second word comes from hold.
        cs_low();
        push_tx(8'h77);
        spi_word(8'h12, 8, got);
        check("b2b rx_valid 1", rx_valid, 1'b1);
        check("b2b rx_data 1", rx_data, 8'h12);
        check("b2b miso 1", got, 8'h00);
        ack_rx();
        check("b2b rx_valid cleared", rx_valid, 1'b0);
        spi_word(8'h34, 8, got);
        check("b2b rx_valid 2", rx_valid, 1'b1);
        check("b2b rx_data 2", rx_data, 8'h34);
        check("b2b miso 2", got, 8'h77);
        ack_rx();
        cs_high();
        check("b2b tx_ready", tx_ready, 1'b1);

        // Partial word aborted by cs, then a full word.
        cs_low();
        spi_word(8'h0A, 5, got);
        cs_high();
        check("partial rx_valid", rx_valid, 1'b0);
        check("partial busy", busy, 1'b0);
        cs_low();
        spi_word(8'hFF, 8, got);
        cs_high();
        check("after partial rx_valid", rx_valid, 1'b1);
        check("after partial rx_data", rx_data, 8'hFF);
        ack_rx();

        // Two words with no rx acknowledge.
`ifdef SPI_SLAVE_OVERRUN_EN
        exp_ovr = 1'b1;
`else
        exp_ovr = 1'b0;
`endif
        cs_low();
        spi_word(8'h01, 8, got);
        spi_word(8'h02, 8, got);
        cs_high();
        check("overrun rx_data", rx_data, 8'h02);
        check("overrun rx_valid", rx_valid, 1'b1);
        check("overrun flag", overrun, exp_ovr);
        ack_rx();
        check("overrun cleared", overrun, 1'b0);
        check("overrun rx_valid cleared", rx_valid, 1'b0);

        // Reset in the middle of a word, with a word held.
        cs_low();
        spi_word(8'hC6, 4, got);
        push_tx(8'hEE);
        check("pre-reset tx_ready", tx_ready, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset miso",     miso,     1'b0);
        check("midreset rx_data",  rx_data,  8'h00);
        check("midreset rx_valid", rx_valid, 1'b0);
        check("midreset tx_ready", tx_ready, 1'b1);
        check("midreset busy",     busy,     1'b0);
        check("midreset overrun",  overrun,  1'b0);
        spi_word(8'h5A, 8, got);
        check("no-cs-cycle rx_valid", rx_valid, 1'b0);
        check("no-cs-cycle busy", busy, 1'b0);
        cs_high();
        cs_low();
        spi_word(8'h96, 8, got);
        cs_high();
        check("post-reset rx_valid", rx_valid, 1'b1);
        check("post-reset rx_data", rx_data, 8'h96);
        check("post-reset miso", got, DEFAULT_TX);
        ack_rx();

        // Randomized transactions against the response model.
        tx_q.delete();
        for (int t = 0; t < 12; t++) begin
            nw = int'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) begin
                check("rnd tx_ready pre", tx_ready, tx_q.size() == 0);
                qw = 8'($urandom);
                push_tx(qw);
                tx_q.push_back(qw);
            end
            cs_low();
            model_load(exp_miso);
            for (int w = 0; w < nw; w++) begin
                mw = 8'($urandom);
                spi_word(mw, 8, got);
                check("rnd miso word", got, exp_miso);
                check("rnd rx_valid", rx_valid, 1'b1);
                check("rnd rx_data", rx_data, mw);
                ack_rx();
                check("rnd rx_valid cleared", rx_valid, 1'b0);
                model_load(exp_miso);
                if (w < nw - 1 && $urandom_range(0, 1) == 1) begin
                    check("rnd tx_ready mid", tx_ready, tx_q.size() == 0);
                    qw = 8'($urandom);
                    push_tx(qw);
                    tx_q.push_back(qw);
                end
            end
            cs_high();
            check("rnd busy idle", busy, 1'b0);
            check("rnd overrun", overrun, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
